// File: rtl/centroid_filter_if.sv
// Centroid filter bundle: IPU centroid samples in, filtered FIFO head and status out.
// Latency/backpressure live in centroid_filter; oFRAME_CNT exists only with CENTROID_FILTER_FRAME_CNT_EN.
// master = sample source / host side, slave = the filter.
interface centroid_filter_if #(
    parameter int COORD_W = 11
);
    logic [COORD_W-1:0] iX;
    logic [COORD_W-1:0] iY;
    logic               iDVAL;
    logic               iFRAME_END;
    logic [COORD_W-1:0] oX;
    logic [COORD_W-1:0] oY;
    logic               oVALID;
    logic               iREADY;
    logic               oLOCK;
    logic               oLOST;
    logic               oOVF;

`ifdef CENTROID_FILTER_FRAME_CNT_EN
    logic [15:0]        oFRAME_CNT;

    modport master (
        output iX, iY, iDVAL, iFRAME_END, iREADY,
        input  oX, oY, oVALID, oLOCK, oLOST, oOVF, oFRAME_CNT
    );
    modport slave (
        input  iX, iY, iDVAL, iFRAME_END, iREADY,
        output oX, oY, oVALID, oLOCK, oLOST, oOVF, oFRAME_CNT
    );
`else
    modport master (
        output iX, iY, iDVAL, iFRAME_END, iREADY,
        input  oX, oY, oVALID, oLOCK, oLOST, oOVF
    );
    modport slave (
        input  iX, iY, iDVAL, iFRAME_END, iREADY,
        output oX, oY, oVALID, oLOCK, oLOST, oOVF
    );
`endif

endinterface

// File: rtl/centroid_filter.sv
// Target tracker: acquire/track/lost FSM, outlier rejection, shift EMA, output FIFO (CENTROID_FILTER_FRAME_CNT_EN adds frame count).
// Latency: iDVAL at cycle N -> entry at FIFO head at N+2 when the FIFO was empty.
// Backpressure: oVALID/iREADY pop; a push into a full FIFO without a pop is dropped and sets sticky oOVF.
module centroid_filter #(
    parameter int COORD_W     = 11,
    parameter int ALPHA_SHIFT = 2,
    parameter int JUMP_THRESH = 64,
    parameter int LOST_FRAMES = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    centroid_filter_if.slave bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);
    localparam logic [COORD_W:0]  THRESH     = (COORD_W + 1)'(JUMP_THRESH);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOST_FRAMES);
    localparam logic [PTR_W:0]    CNT_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [COORD_W-1:0]  fx, fy, fx_nxt, fy_nxt;
    logic [MISS_W-1:0]   miss, miss_nxt, miss_plus;
    logic                seen, seen_nxt;
    logic                push_q, push_nxt;
    logic                miss_inc;
    logic                lock_q, lost_q;

    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W:0]        adx, ady;
    logic                    near;
    logic [COORD_W-1:0]      ema_x, ema_y;

    // Differences are one bit wider so the full unsigned coordinate range is representable.
    always_comb begin
        dx    = $signed({1'b0, bus.iX} - {1'b0, fx});
        dy    = $signed({1'b0, bus.iY} - {1'b0, fy});
        adx   = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        ady   = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        near  = (adx <= THRESH) && (ady <= THRESH);
        ema_x = fx + COORD_W'(dx >>> ALPHA_SHIFT);
        ema_y = fy + COORD_W'(dy >>> ALPHA_SHIFT);
    end

    assign miss_plus = miss + MISS_W'(1);

    always_comb begin
        state_nxt = state;
        fx_nxt    = fx;
        fy_nxt    = fy;
        miss_nxt  = miss;
        push_nxt  = 1'b0;
        miss_inc  = 1'b0;
        // A sample coinciding with frame end belongs to the ending frame.
        seen_nxt  = bus.iFRAME_END ? 1'b0 : (seen | bus.iDVAL);

        case (state)
            IDLE, LOST: begin
                if (bus.iDVAL) begin
                    fx_nxt    = bus.iX;
                    fy_nxt    = bus.iY;
                    push_nxt  = 1'b1;
                    state_nxt = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (bus.iDVAL) begin
                    push_nxt = 1'b1;
                    if (near) begin
                        fx_nxt    = ema_x;
                        fy_nxt    = ema_y;
                        miss_nxt  = '0;
                        state_nxt = TRACK;
                    end else begin
                        fx_nxt = bus.iX;
                        fy_nxt = bus.iY;
                    end
                end
            end
            TRACK: begin
                if (bus.iDVAL) begin
                    if (near) begin
                        fx_nxt   = ema_x;
                        fy_nxt   = ema_y;
                        push_nxt = 1'b1;
                        miss_nxt = '0;
                    end else begin
                        miss_inc = 1'b1;
                    end
                end else if (bus.iFRAME_END && !seen) begin
                    miss_inc = 1'b1;
                end
                if (miss_inc) begin
                    if (miss_plus == MISS_LIMIT) begin
                        miss_nxt  = '0;
                        state_nxt = LOST;
                    end else begin
                        miss_nxt = miss_plus;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            fx     <= '0;
            fy     <= '0;
            miss   <= '0;
            seen   <= 1'b0;
            push_q <= 1'b0;
            lock_q <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fx     <= fx_nxt;
            fy     <= fy_nxt;
            miss   <= miss_nxt;
            seen   <= seen_nxt;
            push_q <= push_nxt;
            lock_q <= (state == TRACK);
            lost_q <= (state == LOST);
        end
    end

    // Output FIFO; fx/fy already hold the updated filter value while push_q is high.
    logic [COORD_W-1:0] mem_x [FIFO_DEPTH];
    logic [COORD_W-1:0] mem_y [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic [COORD_W-1:0] hold_x, hold_y;
    logic               ovf;
    logic               fifo_full, fifo_vld, pop, wr_en;

    assign fifo_full = (count == CNT_FULL);
    assign fifo_vld  = (count != '0);
    assign pop       = fifo_vld & bus.iREADY;
    assign wr_en     = push_q & (~fifo_full | pop);

    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem_x[wr_ptr] <= fx;
            mem_y[wr_ptr] <= fy;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_x <= '0;
            hold_y <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                hold_x <= mem_x[rd_ptr];
                hold_y <= mem_y[rd_ptr];
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (push_q && fifo_full && !pop) ovf <= 1'b1;
        end
    end

    assign bus.oX     = fifo_vld ? mem_x[rd_ptr] : hold_x;
    assign bus.oY     = fifo_vld ? mem_y[rd_ptr] : hold_y;
    assign bus.oVALID = fifo_vld;
    assign bus.oLOCK  = lock_q;
    assign bus.oLOST  = lost_q;
    assign bus.oOVF   = ovf;

`ifdef CENTROID_FILTER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] mem_c [FIFO_DEPTH];
    logic [15:0] hold_c;

    always_ff @(posedge iCLK) begin
        if (wr_en) mem_c[wr_ptr] <= frame_cnt;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            frame_cnt <= '0;
            hold_c    <= '0;
        end else begin
            if (bus.iFRAME_END) frame_cnt <= frame_cnt + 16'd1;
            if (pop)            hold_c    <= mem_c[rd_ptr];
        end
    end

    assign bus.oFRAME_CNT = fifo_vld ? mem_c[rd_ptr] : hold_c;
`endif

endmodule

// File: doc/centroid_filter.md
Name: centroid_filter

Overview:
- Downstream consumer of the IPU's per-frame red-target centroid (oX/oY/oDVAL).
- Acquires and tracks the target, rejects outlier jumps, smooths coordinates with a shift-based exponential moving average (EMA), and flags target loss.
- Presents filtered coordinates to the host/CPU side through a small valid/ready FIFO.

Parameters:
- COORD_W, 11, coordinate width; matches IPU oX/oY.
- ALPHA_SHIFT, 2, EMA weight = 1/2^ALPHA_SHIFT.
- JUMP_THRESH, 64, maximum per-axis |sample - filtered| accepted while locked.
- LOST_FRAMES, 8, consecutive missed/rejected frames before declaring loss.
- FIFO_DEPTH, 4, output FIFO entries; power of two.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset; asynchronous, active-low (asserted when 0).
- iX  in  COORD_W  IPU centroid X.
- iY  in  COORD_W  IPU centroid Y.
- iDVAL  in  1  one-cycle pulse; iX/iY valid.
- iFRAME_END  in  1  one-cycle pulse at end of each camera frame.
- oX  out  COORD_W  FIFO head, filtered X.
- oY  out  COORD_W  FIFO head, filtered Y.
- oVALID  out  1  FIFO non-empty.
- iREADY  in  1  consumer accepts head when oVALID & iREADY.
- oLOCK  out  1  state == TRACK.
- oLOST  out  1  state == LOST.
- oOVF  out  1  sticky; an entry was dropped because the FIFO was full.

Behaviour:
- Reset (iRST=0, async):
  - State = IDLE; filter regs, miss counter and FIFO pointers = 0.
  - Outputs oX=oY=0, oVALID=0, oLOCK=0, oLOST=0, oOVF=0.
  - Reset mid-operation discards all FIFO contents.
- Sample test: dx = iX - fX and dy = iY - fY, computed as signed COORD_W+1 values.
  - "Near" = |dx| <= JUMP_THRESH and |dy| <= JUMP_THRESH.
- Filter operations:
  - Load: fX = iX, fY = iY.
  - EMA: fX = fX + (dx >>> ALPHA_SHIFT), arithmetic shift; same for Y.
  - The EMA result always lies between fX and iX, so no clamp is needed.
- States:
  - IDLE: on iDVAL, load, go to ACQUIRE.
  - ACQUIRE: on iDVAL, if near, EMA and go to TRACK; else load and stay.
  - TRACK: iDVAL & near: EMA, miss = 0. iDVAL & not near: filter held, miss++.
  - TRACK, frame end: iFRAME_END with no iDVAL since the previous iFRAME_END gives miss++.
  - TRACK, loss: miss reaching LOST_FRAMES goes to LOST, miss = 0.
  - LOST: on iDVAL, load, go to ACQUIRE.
  - Missing frames in IDLE/ACQUIRE/LOST are ignored.
- Simultaneous iDVAL and iFRAME_END: the sample belongs to the ending frame, so there is no frame miss; the sample itself is still tested.
- Push rule:
  - Every load or EMA update pushes {fX_new, fY_new} into the FIFO on the cycle after iDVAL.
  - Rejected samples push nothing.
  - Latency: iDVAL at cycle N gives the entry at the FIFO head with oVALID=1 at N+2 when the FIFO was empty (N+1 register update, N+2 push visible).
- FIFO:
  - Pop on oVALID & iREADY.
  - Full with push and no pop: the new entry is dropped and oOVF is set (sticky until reset).
  - Full with push and pop in the same cycle: both happen, no drop.
  - Empty: oX/oY hold the last popped value (0 after reset), oVALID=0.
- oLOCK and oLOST are registered decodes of the state; they change the cycle after the transition.

Optional Feature:
- Macro: CENTROID_FILTER_FRAME_CNT_EN.
- Defined:
  - Adds output port oFRAME_CNT [15:0], counting iFRAME_END pulses.
  - Reset 0; wraps 16'hFFFF to 0.
  - Sampled into each FIFO entry and presented alongside oX/oY.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- Reset, then iDVAL (100,200): ACQUIRE; oVALID=1 two cycles later with (100,200); oLOCK=0.
- From (100,200), iDVAL (140,200): TRACK; oLOCK=1; output (110,200). Next (140,200): output (117,200), since 30>>>2 = 7.
- TRACK at (110,200), iDVAL (300,200): rejected; no push; filter unchanged; miss=1.
- TRACK, 8 iFRAME_END pulses with no iDVAL: oLOST=1 after the 8th. Next iDVAL (50,60): output (50,60), oLOST=0, oLOCK=0.
- iREADY=0, 5 accepted samples: first 4 queued, 5th dropped, oOVF=1. Raise iREADY: pops in order; oOVF stays 1.
- Full FIFO, push and pop in the same cycle: no drop, oOVF unchanged. Assert iRST mid-stream: oVALID=0 immediately.
